f_to_d_queue: RTL and testbench
===============================

// Module: f_to_d_queue
// PURPOSE
//   Parametrised fetch->decode buffer that replaces the single F/D pipeline register.
//   Adds a DEPTH-entry FIFO so fetch keeps running while decode or memory stalls.
//   Adds a valid/ready handshake on the fetch side and a flush that kills all in-flight fetches.
//   Sits between the fetch stage and the decode stage; the D_* outputs are registered.
// PARAMETERS
//   XLEN     32            instruction width
//   PC_BITS  5             PC width
//   DEPTH    4             FIFO entries; power of 2, >=2
//   NOP      32'h2000_0000 instruction presented when D_valid=0 (addi r0,r0,0)
// PORTS
//   clk         in   1               clock, rising edge
//   rst         in   1               reset, synchronous, active-high
//   F_valid     in   1               fetch presents an instruction
//   F_ready     out  1               buffer accepts the instruction this cycle
//   F_pc        in   PC_BITS         fetched PC
//   F_inst      in   XLEN            fetched instruction
//   F_BP_taken  in   1               branch-predictor taken flag for F_pc
//   stall_D     in   1               decode hazard stall
//   MEM_stall   in   1               memory-stage stall
//   flush       in   1               EX resolved taken/mispredict; kill all buffered fetches
//   D_valid     out  1               D_* holds a live instruction
//   D_pc        out  PC_BITS         decode PC
//   D_inst      out  XLEN            decode instruction (NOP when D_valid=0)
//   D_BP_taken  out  1               prediction flag travelling with D_inst
//   occupancy   out  $clog2(DEPTH)+1 FIFO entries held, excluding the D register
// BEHAVIOUR
//   Reset: wr_ptr=rd_ptr=count=0, D_valid=0, D_pc=0, D_inst=NOP, D_BP_taken=0.
//   F_ready = !rst & !flush & (count<DEPTH), combinational.
//     No credit is given for a same-cycle pop.
//   push = F_valid & F_ready.
//   advance = !stall_D & !MEM_stall.
//   Priority per cycle: rst > flush > advance/hold.
//   flush:
//     pointers and count go to 0; D_valid=0, D_inst=NOP, D_BP_taken=0; D_pc holds.
//     Overrides stalls. No push occurs in the flush cycle.
//   advance, count>0:
//     D regs load the FIFO head and set D_valid=1; rd_ptr++.
//     A push in the same cycle writes at wr_ptr; count stays unchanged.
//   advance, count==0, push:
//     Bypass: D regs load F_pc/F_inst/F_BP_taken, D_valid=1; FIFO untouched.
//     Latency F->D is 1 cycle, identical to a plain pipeline register.
//   advance, count==0, no push:
//     D_valid=0, D_inst=NOP, D_BP_taken=0; D_pc holds.
//   hold (!advance):
//     D regs unchanged.
//     A push writes the FIFO (count++), including the case count==0.
//   Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
//   Strict FIFO order: bypass only when count==0.
//   occupancy = count.
//   Never drops an accepted instruction except on flush or rst.
// TESTING
//   T1 reset:
//     rst=1 for 2 cycles -> D_valid=0, D_inst=0x20000000, D_pc=0, occupancy=0.
//     F_ready=0 during rst, 1 after.
//   T2 streaming:
//     F_valid=1 with pc 1,2,3, no stalls -> D_pc=1,2,3 on successive cycles.
//     D_valid=1 and occupancy=0 throughout.
//   T3 stall fill (DEPTH=4):
//     D holds pc1 with stall_D=1; offer pc2..6 -> pc2..5 accepted, occupancy=4, F_ready=0, pc6 held.
//     Release stall -> D_pc=2,3,4,5,6 on consecutive cycles.
//   T4 flush:
//     occupancy=3 with MEM_stall=1; flush=1 and F_valid=1 (pc9) in the same cycle.
//     Next cycle: occupancy=0, D_valid=0, D_inst=NOP, D_BP_taken=0; pc9 never appears on D.
//   T5 wrap:
//     12 instructions pushed under alternating stall_D.
//     D_pc sequence is exactly 1..12 across pointer wrap; D_BP_taken pattern preserved.
//   T6 reset mid-op:
//     occupancy=2, D_valid=1, assert rst -> next cycle all reset values, occupancy=0.

Source files
------------

// File: rtl/f_to_d_queue_if.sv
// Fetch->decode buffer bus: fetch-side handshake, decode-side stall/flush
// controls and the registered decode outputs, with one modport per side.
interface f_to_d_queue_if #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 5,
  parameter int DEPTH   = 4
);
  // Handshake: an instruction transfers on a rising clk edge where F_valid
  // and F_ready are both high. F_ready is combinational, never depends on
  // F_valid, and ignores any pop happening in the same cycle.
  logic                     F_valid;
  logic                     F_ready;
  logic [PC_BITS-1:0]       F_pc;
  logic [XLEN-1:0]          F_inst;
  logic                     F_BP_taken;
  logic                     stall_D;
  logic                     MEM_stall;
  logic                     flush;
  logic                     D_valid;
  logic [PC_BITS-1:0]       D_pc;
  logic [XLEN-1:0]          D_inst;
  logic                     D_BP_taken;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output F_valid, F_pc, F_inst, F_BP_taken, stall_D, MEM_stall, flush,
    input  F_ready, D_valid, D_pc, D_inst, D_BP_taken, occupancy
  );

  modport slave (
    input  F_valid, F_pc, F_inst, F_BP_taken, stall_D, MEM_stall, flush,
    output F_ready, D_valid, D_pc, D_inst, D_BP_taken, occupancy
  );
endinterface

// File: rtl/f_to_d_queue.sv
// Fetch->decode buffer: DEPTH-entry FIFO in front of a registered decode
// stage, with empty-FIFO bypass and a flush that discards all buffered fetches.
module f_to_d_queue #(
  parameter int              XLEN    = 32,
  parameter int              PC_BITS = 5,
  parameter int              DEPTH   = 4,
  parameter logic [XLEN-1:0] NOP     = XLEN'(32'h2000_0000)
) (
  input  logic clk,
  input  logic rst,
  f_to_d_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [XLEN-1:0]    inst;
    logic               bp;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          dreg_q, dreg_d;
  logic            d_valid_q, d_valid_d;

  logic            f_ready;
  logic            push;
  logic            advance;
  entry_t          f_entry;

  always_comb begin
    f_entry   = '{pc: bus.F_pc, inst: bus.F_inst, bp: bus.F_BP_taken};
    f_ready   = !rst && !bus.flush && (count_q < CW'(DEPTH));
    push      = bus.F_valid && f_ready;
    advance   = !bus.stall_D && !bus.MEM_stall;

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dreg_d    = dreg_q;
    d_valid_d = d_valid_q;

    if (bus.flush) begin
      // D_pc deliberately keeps its last value; only the live bits are killed.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      d_valid_d   = 1'b0;
      dreg_d.inst = NOP;
      dreg_d.bp   = 1'b0;
    end else if (advance) begin
      if (count_q != '0) begin
        dreg_d    = mem_q[rd_ptr_q];
        d_valid_d = 1'b1;
        rd_ptr_d  = rd_ptr_q + 1'b1;
        if (push) begin
          mem_d[wr_ptr_q] = f_entry;
          wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end else if (push) begin
        // Empty FIFO: behave exactly like a plain pipeline register.
        dreg_d    = f_entry;
        d_valid_d = 1'b1;
      end else begin
        d_valid_d   = 1'b0;
        dreg_d.inst = NOP;
        dreg_d.bp   = 1'b0;
      end
    end else if (push) begin
      mem_d[wr_ptr_q] = f_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      count_d         = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      d_valid_q <= 1'b0;
      dreg_q    <= '{pc: '0, inst: NOP, bp: 1'b0};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      d_valid_q <= d_valid_d;
      dreg_q    <= dreg_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.F_ready    = f_ready;
  assign bus.D_valid    = d_valid_q;
  assign bus.D_pc       = dreg_q.pc;
  assign bus.D_inst     = dreg_q.inst;
  assign bus.D_BP_taken = dreg_q.bp;
  assign bus.occupancy  = count_q;
endmodule

// File: tb/tb_f_to_d_queue.sv
// Bench for f_to_d_queue: directed scenarios plus random traffic, checked
// against a queue-based reference of accepted-but-not-yet-decoded fetches.
module tb_f_to_d_queue;
  localparam int          XLEN    = 32;
  localparam int          PC_BITS = 5;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] NOP     = 32'h2000_0000;
  localparam int          EW      = PC_BITS + XLEN + 1;

  localparam int EV_HOLD  = 0;
  localparam int EV_LOAD  = 1;
  localparam int EV_INVAL = 2;
  localparam int EV_RST   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  f_to_d_queue_if #(.XLEN(XLEN), .PC_BITS(PC_BITS), .DEPTH(DEPTH)) bus();

  f_to_d_queue #(.XLEN(XLEN), .PC_BITS(PC_BITS), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ev     = EV_HOLD;
  bit started  = 1'b0;
  bit acc_flag = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: acceptance decided from the model's own buffer size;
  // exp_q holds every accepted fetch that decode has not yet received.
  always @(posedge clk) begin
    bit ready_m;
    if (rst) begin
      chk("f_ready_in_rst", bus.F_ready, 1'b0);
      exp_q.delete();
      ev       = EV_RST;
      started  = 1'b1;
      acc_flag = 1'b0;
    end else if (started) begin
      ready_m = (exp_q.size() < DEPTH) && !bus.flush;
      chk("f_ready", bus.F_ready, ready_m);
      acc_flag = bus.F_valid && ready_m;
      if (bus.flush) begin
        exp_q.delete();
        ev = EV_INVAL;
      end else begin
        if (acc_flag) exp_q.push_back({bus.F_pc, bus.F_inst, bus.F_BP_taken});
        if (!bus.stall_D && !bus.MEM_stall) ev = (exp_q.size() > 0) ? EV_LOAD : EV_INVAL;
        else ev = EV_HOLD;
      end
    end
  end

  // Monitor: consumes the expected head whenever decode takes a new entry,
  // then compares the whole decode register and occupancy.
  logic               exp_dv;
  logic [PC_BITS-1:0] exp_pc;
  logic [XLEN-1:0]    exp_inst;
  logic               exp_bp;
  logic [EW-1:0]      head;

  always @(negedge clk) begin
    if (started) begin
      case (ev)
        EV_RST: begin
          exp_dv = 1'b0; exp_pc = '0; exp_inst = NOP; exp_bp = 1'b0;
        end
        EV_LOAD: begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
          end else begin
            head = exp_q.pop_front();
            {exp_pc, exp_inst, exp_bp} = head;
            exp_dv = 1'b1;
          end
        end
        EV_INVAL: begin
          exp_dv = 1'b0; exp_inst = NOP; exp_bp = 1'b0;
        end
        default: ;
      endcase
      chk("d_valid",    bus.D_valid,    exp_dv);
      chk("d_pc",       bus.D_pc,       exp_pc);
      chk("d_inst",     bus.D_inst,     exp_inst);
      chk("d_bp_taken", bus.D_BP_taken, exp_bp);
      chk("occupancy",  bus.occupancy,  exp_q.size());
    end
  end

  task automatic step(input bit fv, input logic [PC_BITS-1:0] pc, input logic [XLEN-1:0] inst,
                      input bit bp, input bit sd, input bit ms, input bit fl, input bit r);
    rst            = r;
    bus.F_valid    = fv;
    bus.F_pc       = pc;
    bus.F_inst     = inst;
    bus.F_BP_taken = bp;
    bus.stall_D    = sd;
    bus.MEM_stall  = ms;
    bus.flush      = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit sd, input bit ms);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, sd, ms, 1'b0, 1'b0);
  endtask

  // Holds one fetch on the bus until the buffer takes it (bounded).
  task automatic offer(input logic [PC_BITS-1:0] pc, input bit bp, input bit sd, input bit ms);
    logic [XLEN-1:0] inst;
    int n;
    inst = $urandom;
    n = 0;
    do begin
      step(1'b1, pc, inst, bp, sd, ms, 1'b0, 1'b0);
      n++;
    end while (!acc_flag && n < 20);
    if (!acc_flag) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: pc %0d not accepted within 20 cycles", pc);
    end
  endtask

  initial begin
    // T1 reset
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);

    // T2 streaming
    offer(5'd1, 1'b0, 1'b0, 1'b0);
    offer(5'd2, 1'b1, 1'b0, 1'b0);
    offer(5'd3, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);

    // T3 stall fill: pc6 refused while full, then drains in order
    offer(5'd1, 1'b0, 1'b0, 1'b0);
    for (int p = 2; p <= 5; p++) offer(5'(p), p[0], 1'b1, 1'b0);
    step(1'b1, 5'd6, 32'h0000_0066, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd6, 32'h0000_0066, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    offer(5'd6, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b0, 1'b0);

    // T4 flush with a same-cycle fetch that must be dropped
    offer(5'd7, 1'b1, 1'b0, 1'b0);
    offer(5'd10, 1'b1, 1'b0, 1'b1);
    offer(5'd11, 1'b0, 1'b0, 1'b1);
    offer(5'd12, 1'b1, 1'b0, 1'b1);
    step(1'b1, 5'd9, 32'h0000_0099, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b0);

    // T5 wrap under alternating stall_D
    for (int i = 1; i <= 12; i++) offer(5'(i), 1'($urandom_range(0, 1)), 1'(i % 2), 1'b0);
    idle(8, 1'b0, 1'b0);

    // T6 reset mid-operation
    offer(5'd20, 1'b1, 1'b0, 1'b0);
    offer(5'd21, 1'b1, 1'b1, 1'b0);
    offer(5'd22, 1'b0, 1'b1, 1'b0);
    step(1'b1, 5'd23, 32'h0000_0023, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), 5'($urandom), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 2),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end
    idle(10, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
